shift_normalizer: RTL and testbench
===================================

Name: shift_normalizer

Overview:
- Multi-cycle normalize unit for the CPU shifter path; it is the inverse of a logical shift.
- Given a 32-bit operand, it finds the shift amount that puts the highest set bit at bit 31 (left-normalize, leading-zero count) or the lowest set bit at bit 0 (right-normalize, trailing-zero count).
- It returns the normalized word, the amount and a zero flag.
- It uses a 5-step binary search, one step per clock, with a start/busy/done handshake, and sits beside the barrel shifter under ALU control.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported. SHAMT_OUT is log2(WIDTH)+1 bits wide.
- RIGHT_EN, 1, when 0 the FS_NRM_R function is treated as an invalid FS and start is ignored.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse, sampled in IDLE only
- FS  in  5  function select: 5'h0F = normalize left (FS_NRM_L), 5'h10 = normalize right (FS_NRM_R)
- T  in  32  operand, sampled with start
- busy  out  1  high while the search is running
- done  out  1  one-cycle pulse when results become valid
- NORM_OUT  out  32  normalized word
- SHAMT_OUT  out  6  shift amount, 0..32
- Z  out  1  operand was zero

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, busy=0, done=0, NORM_OUT=0, SHAMT_OUT=0, Z=0, step counter=0. A reset during RUN aborts the operation; no done pulse follows.
- States: IDLE, RUN.
- IDLE -> RUN at edge e0 when start=1 and FS is valid:
  - Valid FS values are FS_NRM_L, and FS_NRM_R when RIGHT_EN=1.
  - On this edge: load the working register with T, clear the amount accumulator, latch the direction, set the zero flag = (T==0), busy=1.
  - Start with any other FS is ignored: stay in IDLE, outputs unchanged.
- RUN, edges e1..e5, step k = 16, 8, 4, 2, 1 in that order:
  - Left: if working[31:32-k]==0, shift the working register left by k (zero fill) and add k to the accumulator.
  - Right: if working[k-1:0]==0, shift right by k (zero fill) and add k.
  - Otherwise leave the register and accumulator unchanged.
- At e5, all in the same edge:
  - NORM_OUT <= working result, SHAMT_OUT <= accumulator, Z <= zero flag.
  - done=1 for exactly one cycle, busy=0, state -> IDLE.
- Latency: done is high in the cycle after e5, i.e. 5 clocks after the start edge. The latency is fixed and independent of the data.
- Zero operand: the search alone would give 31. Instead, force SHAMT_OUT=32 and NORM_OUT=0, with Z=1.
- Outputs hold their last result until the next completion. They do not change at start or during RUN.
- start while busy=1 is ignored, with no queuing. start in the same cycle as done (state is already IDLE) is accepted and begins a new operation.
- FS and T are only sampled at the start edge; changes during RUN have no effect.
- No carry output. No other flags.

Decomposition:
- Shared ALU package: FS_NRM_L=5'h0F and FS_NRM_R=5'h10, alongside the existing shift codes 0C/0D/0E, plus the state encoding localparams.
- One combinational sub-module, norm_step:
  - Inputs: working word, step size k, direction.
  - Outputs: next word, hit bit.
  - Instantiated once and driven by the step counter.

Test Plan:
- FS=0x0F, T=0x0000_1234, start pulse -> done exactly 5 cycles later; NORM_OUT=0x91A0_0000, SHAMT_OUT=19, Z=0; busy high for 5 cycles.
- FS=0x10, T=0x0000_0A00 -> NORM_OUT=0x0000_0005, SHAMT_OUT=9, Z=0.
- T=0x0000_0000, both FS values -> NORM_OUT=0, SHAMT_OUT=32, Z=1.
- FS=0x0F, T=0x8000_0000 -> SHAMT_OUT=0, NORM_OUT=0x8000_0000. FS=0x10, same T -> SHAMT_OUT=31, NORM_OUT=0x0000_0001.
- Second start at cycle 2 of RUN with different T -> ignored; first result is unchanged. start asserted in the done cycle -> accepted, next done 5 cycles later.
- reset_n low at cycle 3 of RUN -> busy=0 and all outputs 0 immediately; no done pulse. start with FS=0x0C -> ignored, busy stays 0.

Source files
------------

// File: rtl/shift_normalizer_pkg.sv
// Shared ALU definitions for the shifter path: function-select codes,
// normalizer state encoding and the search step-size helper.
package shift_normalizer_pkg;

  localparam logic [4:0] FS_SHL   = 5'h0C;
  localparam logic [4:0] FS_SHR   = 5'h0D;
  localparam logic [4:0] FS_SAR   = 5'h0E;
  localparam logic [4:0] FS_NRM_L = 5'h0F;
  localparam logic [4:0] FS_NRM_R = 5'h10;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {IDLE = ST_IDLE, RUN = ST_RUN} state_t;
  typedef enum logic {DIR_L = 1'b0, DIR_R = 1'b1} dir_t;

  // Step counter runs down 4..0, giving k = 16, 8, 4, 2, 1.
  function automatic logic [4:0] step_size(input logic [2:0] cnt);
    return 5'd1 << cnt;
  endfunction

endpackage

// File: rtl/shift_normalizer_norm_step.sv
// One binary-search step: tests the k edge bits on the side being
// normalized and offers the word shifted by k when they are all zero.
module norm_step
  import shift_normalizer_pkg::*;
(
  input  logic [31:0] word,
  input  logic [4:0]  k,
  input  dir_t        dir,
  output logic [31:0] next_word,
  output logic        hit
);

  logic [31:0] mask;

  always_comb begin
    mask      = '0;
    next_word = '0;
    hit       = 1'b0;
    if (dir == DIR_L) begin
      mask      = ~(32'hFFFF_FFFF >> k);
      next_word = word << k;
    end else begin
      mask      = ~(32'hFFFF_FFFF << k);
      next_word = word >> k;
    end
    hit = (word & mask) == '0;
  end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalize unit: leading/trailing-zero count by a 5-step
// binary search, returning the normalized word, amount and zero flag.
//
// state | meaning
// IDLE  | waiting for start with a valid FS; results held
// RUN   | one search step per clock, k = 16, 8, 4, 2, 1
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int RIGHT_EN = 1,
  localparam int SHW     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] NORM_OUT,
  output logic [SHW-1:0]   SHAMT_OUT,
  output logic             Z
);

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   acc;
  dir_t             dir;
  logic             zflag;
  logic [4:0]       k;
  logic [WIDTH-1:0] step_word;
  logic             step_hit;
  logic             fs_ok, launch, last;

  assign k = step_size(cnt);

  norm_step u_step (
    .word      (work),
    .k         (k),
    .dir       (dir),
    .next_word (step_word),
    .hit       (step_hit)
  );

  always_comb begin
    fs_ok = (FS == FS_NRM_L) || ((RIGHT_EN != 0) && (FS == FS_NRM_R));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start && fs_ok) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 3'd0) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      work      <= '0;
      acc       <= '0;
      dir       <= DIR_L;
      zflag     <= 1'b0;
      done      <= 1'b0;
      NORM_OUT  <= '0;
      SHAMT_OUT <= '0;
      Z         <= 1'b0;
    end else begin
      done <= last;
      if (launch) begin
        work  <= T;
        acc   <= '0;
        dir   <= (FS == FS_NRM_R) ? DIR_R : DIR_L;
        zflag <= (T == '0);
        cnt   <= 3'd4;
      end else if (state == RUN) begin
        if (step_hit) begin
          work <= step_word;
          acc  <= acc + {1'b0, k};
        end
        if (cnt != 3'd0) cnt <= cnt - 3'd1;
      end
      // A zero operand would search out to 31; report a full-width shift instead.
      if (last) begin
        Z <= zflag;
        if (zflag) begin
          NORM_OUT  <= '0;
          SHAMT_OUT <= SHW'(WIDTH);
        end else begin
          NORM_OUT  <= step_hit ? step_word : work;
          SHAMT_OUT <= acc + (step_hit ? {1'b0, k} : '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed-vector bench for shift_normalizer with hand-computed results.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  FS = 5'h00;
  logic [31:0] T = '0;
  logic        busy, done, Z;
  logic [31:0] NORM_OUT;
  logic [5:0]  SHAMT_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  shift_normalizer #(.WIDTH(32), .RIGHT_EN(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .FS        (FS),
    .T         (T),
    .busy      (busy),
    .done      (done),
    .NORM_OUT  (NORM_OUT),
    .SHAMT_OUT (SHAMT_OUT),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  fs;
    logic [31:0] t;
    logic [31:0] norm;
    logic [5:0]  sh;
    logic        z;
  } vec_t;

  vec_t vecs[9] = '{
    '{5'h0F, 32'h0000_1234, 32'h91A0_0000, 6'd19, 1'b0},
    '{5'h10, 32'h0000_0A00, 32'h0000_0005, 6'd9,  1'b0},
    '{5'h0F, 32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1},
    '{5'h10, 32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1},
    '{5'h0F, 32'h8000_0000, 32'h8000_0000, 6'd0,  1'b0},
    '{5'h10, 32'h8000_0000, 32'h0000_0001, 6'd31, 1'b0},
    '{5'h0F, 32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0},
    '{5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0,  1'b0},
    '{5'h10, 32'h00F0_0000, 32'h0000_000F, 6'd20, 1'b0}
  };

  // Ends #1 after the start edge with start released.
  task automatic launch(input logic [4:0] fs, input logic [31:0] t);
    @(negedge clk);
    start = 1'b1; FS = fs; T = t;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start edge until done, bounded.
  task automatic wait_done(input string tag, output int n, output int nbusy);
    n = 0;
    nbusy = busy ? 1 : 0;
    while (n < 12) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      if (busy) nbusy++;
    end
    chk({tag, " latency"}, 32'(n), 32'd5);
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, " norm"}, NORM_OUT, v.norm);
    chk({tag, " shamt"}, 32'(SHAMT_OUT), 32'(v.sh));
    chk({tag, " z"}, 32'(Z), 32'(v.z));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   n, nb, seen;
    vec_t v;

    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst norm", NORM_OUT, 32'd0);
    chk("rst shamt", 32'(SHAMT_OUT), 32'd0);
    chk("rst z", 32'(Z), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      launch(v.fs, v.t);
      chk($sformatf("v%0d busy_start", i), 32'(busy), 32'd1);
      wait_done($sformatf("v%0d", i), n, nb);
      chk($sformatf("v%0d busy_cycles", i), 32'(nb), 32'd5);
      chk_result($sformatf("v%0d", i), v);
      @(posedge clk); #1;
      chk($sformatf("v%0d done_pulse", i), 32'(done), 32'd0);
    end

    // Second start mid-run is dropped; start in the done cycle is taken.
    launch(5'h0F, 32'h0000_1234);
    @(negedge clk);
    start = 1'b1; FS = 5'h0F; T = 32'h0000_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ovl busy", 32'(busy), 32'd1);
    n = 1;
    while (n < 12) begin
      @(posedge clk); n++; #1;
      if (done) break;
    end
    chk("ovl latency", 32'(n), 32'd5);
    chk_result("ovl", vecs[0]);
    start = 1'b1; FS = 5'h10; T = 32'h0000_0A00;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b held_norm", NORM_OUT, 32'h91A0_0000);
    wait_done("b2b", n, nb);
    chk_result("b2b", vecs[1]);

    // Invalid FS: ignored, results held.
    launch(5'h0C, 32'h0000_0100);
    chk("badfs busy", 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("badfs busy_later", 32'(busy), 32'd0);
    chk("badfs done", 32'(done), 32'd0);
    chk("badfs norm_held", NORM_OUT, 32'h0000_0005);
    chk("badfs shamt_held", 32'(SHAMT_OUT), 32'd9);

    // Reset in the middle of a run aborts with no done.
    launch(5'h0F, 32'h0000_1234);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort norm", NORM_OUT, 32'd0);
    chk("abort shamt", 32'(SHAMT_OUT), 32'd0);
    chk("abort z", 32'(Z), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort no_done", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
